float_rounder: RTL and testbench

FLOAT_ROUNDER -- requirements
Module: float_rounder

---
 rtl/float_rounder.sv | 211 +++++++++++++++++++++
 tb/tb_float_rounder.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/float_rounder.sv
// float_rounder: two-stage IEEE-754 binary32 rounding and packing pipeline.
// Stage 1 denormalises tiny results and decides the rounding increment.
// Stage 2 renormalises, detects overflow, packs the word and builds fflags.
// Optional feature macro: FPU_ROUND_SUBNORMAL_EN (gradual underflow). When it
// is undefined, tiny inputs flush to signed zero and no shifter is built.
module float_rounder (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               valid_in,
  output logic               ready_out,
  output logic               valid_out,
  input  logic               ready_in,
  input  logic [23:0]        man_in,
  input  logic signed [9:0]  exp_in,
  input  logic               sgn_in,
  input  logic               round_bit,
  input  logic               sticky_bit,
  input  logic               skip_round,
  input  logic               IV_in,
  input  logic               DZ_in,
  input  logic [2:0]         rm,
  output logic [31:0]        float_out,
  output logic [4:0]         fflags
);

  // Rounding increment for each mode; unknown codes fall back to RNE.
  function automatic logic round_inc(input logic [2:0] mode, input logic sgn,
                                     input logic lsb, input logic rnd,
                                     input logic stk);
    case (mode)
      3'b001:  round_inc = 1'b0;
      3'b010:  round_inc = sgn & (rnd | stk);
      3'b011:  round_inc = ~sgn & (rnd | stk);
      3'b100:  round_inc = rnd;
      default: round_inc = rnd & (stk | lsb);
    endcase
  endfunction

  // Overflow result: infinity when the mode rounds away from zero in the
  // direction of the sign, otherwise the largest finite magnitude.
  function automatic logic [31:0] ovf_result(input logic [2:0] mode,
                                             input logic sgn);
    logic to_inf;
    case (mode)
      3'b001:  to_inf = 1'b0;
      3'b010:  to_inf = sgn;
      3'b011:  to_inf = ~sgn;
      default: to_inf = 1'b1;
    endcase
    ovf_result = to_inf ? {sgn, 8'hFF, 23'd0} : {sgn, 8'hFE, 23'h7FFFFF};
  endfunction

  logic               vld_p1;
  logic               vld_p2;
  logic               s2_free;

  logic               tiny_p0;
  logic [23:0]        man_dn_p0;
  logic               rnd_dn_p0;
  logic               stk_dn_p0;
  logic               subn_p0;
  logic               flush_p0;
  logic signed [9:0]  exp_dn_p0;
  logic               inc_p0;
  logic               nx_p0;
  logic [24:0]        rounded_p0;

  logic               skip_p1;
  logic               sgn_p1;
  logic [24:0]        rounded_p1;
  logic signed [9:0]  exp_p1;
  logic               subn_p1;
  logic               flush_p1;
  logic               nx_p1;
  logic               tiny_p1;
  logic [2:0]         rm_p1;
  logic               nv_p1;
  logic               dz_p1;

  logic               carry_p1;
  logic signed [10:0] exp_r_p1;
  logic               ovf_p1;
  logic [31:0]        res_p1;
  logic [4:0]         flg_p1;

  logic [31:0]        res_p2;
  logic [4:0]         flg_p2;

  // Stage 2 can take a new item when it is empty or is being drained.
  assign s2_free   = ~vld_p2 | ready_in;
  assign ready_out = ~vld_p1 | s2_free;
  assign valid_out = vld_p2;
  assign float_out = res_p2;
  assign fflags    = flg_p2;

  assign tiny_p0 = (exp_in <= 10'sd0);

`ifdef FPU_ROUND_SUBNORMAL_EN
  logic signed [10:0] sh_full_p0;
  logic [4:0]         shamt_p0;
  logic [50:0]        shifted_p0;

  // Denormalise tiny results: shift right by 1-exp, capped at 26 places.
  always_comb begin
    sh_full_p0 = 11'sd1 - $signed({exp_in[9], exp_in});
    shamt_p0   = (sh_full_p0 > 11'sd26) ? 5'd26 : sh_full_p0[4:0];
    shifted_p0 = {man_in, round_bit, 26'd0} >> shamt_p0;
    flush_p0   = 1'b0;
    if (tiny_p0 && !skip_round) begin
      man_dn_p0 = shifted_p0[50:27];
      rnd_dn_p0 = shifted_p0[26];
      stk_dn_p0 = (|shifted_p0[25:0]) | sticky_bit;
      subn_p0   = 1'b1;
      exp_dn_p0 = 10'sd0;
    end else begin
      man_dn_p0 = man_in;
      rnd_dn_p0 = round_bit;
      stk_dn_p0 = sticky_bit;
      subn_p0   = 1'b0;
      exp_dn_p0 = exp_in;
    end
  end
`else
  // Tiny results are flushed in stage 2; the mantissa passes through as is.
  always_comb begin
    man_dn_p0 = man_in;
    rnd_dn_p0 = round_bit;
    stk_dn_p0 = sticky_bit;
    subn_p0   = 1'b0;
    exp_dn_p0 = exp_in;
    flush_p0  = tiny_p0 & ~skip_round;
  end
`endif

  // Round increment and inexact detection on the (possibly shifted) mantissa.
  always_comb begin
    inc_p0     = round_inc(rm, sgn_in, man_dn_p0[0], rnd_dn_p0, stk_dn_p0);
    nx_p0      = flush_p0 | rnd_dn_p0 | stk_dn_p0;
    rounded_p0 = skip_round ? {1'b0, man_in}
                            : ({1'b0, man_dn_p0} + {24'd0, inc_p0});
  end

  // ---- stage 1 register: rounded mantissa and context ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1     <= 1'b0;
      skip_p1    <= 1'b0;
      sgn_p1     <= 1'b0;
      rounded_p1 <= '0;
      exp_p1     <= '0;
      subn_p1    <= 1'b0;
      flush_p1   <= 1'b0;
      nx_p1      <= 1'b0;
      tiny_p1    <= 1'b0;
      rm_p1      <= '0;
      nv_p1      <= 1'b0;
      dz_p1      <= 1'b0;
    end else if (ready_out) begin
      vld_p1 <= valid_in;
      if (valid_in) begin
        skip_p1    <= skip_round;
        sgn_p1     <= sgn_in;
        rounded_p1 <= rounded_p0;
        exp_p1     <= exp_dn_p0;
        subn_p1    <= subn_p0;
        flush_p1   <= flush_p0;
        nx_p1      <= nx_p0 & ~skip_round;
        tiny_p1    <= tiny_p0;
        rm_p1      <= rm;
        nv_p1      <= IV_in;
        dz_p1      <= DZ_in;
      end
    end
  end

  // Renormalise after carry-out, detect overflow, pack result and flags.
  always_comb begin
    carry_p1 = rounded_p1[24];
    exp_r_p1 = {exp_p1[9], exp_p1} + 11'(carry_p1)
             + 11'(subn_p1 & rounded_p1[23]);
    ovf_p1   = (exp_r_p1 >= 11'sd255);
    res_p1   = {sgn_p1, exp_r_p1[7:0], carry_p1 ? 23'd0 : rounded_p1[22:0]};
    flg_p1   = {nv_p1, dz_p1, 1'b0, tiny_p1 & nx_p1, nx_p1};
    if (skip_p1) begin
      res_p1 = {sgn_p1, exp_p1[7:0], rounded_p1[22:0]};
      flg_p1 = {nv_p1, dz_p1, 3'b000};
    end else if (flush_p1) begin
      res_p1 = {sgn_p1, 31'd0};
      flg_p1 = {nv_p1, dz_p1, 3'b011};
    end else if (ovf_p1) begin
      res_p1 = ovf_result(rm_p1, sgn_p1);
      flg_p1 = {nv_p1, dz_p1, 3'b101};
    end
  end

  // ---- stage 2 register: packed output, held while downstream stalls ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p2 <= 1'b0;
      res_p2 <= '0;
      flg_p2 <= '0;
    end else if (s2_free) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        res_p2 <= res_p1;
        flg_p2 <= flg_p1;
      end
    end
  end

endmodule

// File: tb/tb_float_rounder.sv
// Directed testbench for float_rounder with hand-computed expected values.
// Expected subnormal results follow FPU_ROUND_SUBNORMAL_EN as the RTL does.
module tb_float_rounder;

  logic        clk;
  logic        reset_n;
  logic        valid_in;
  logic        ready_out;
  logic        valid_out;
  logic        ready_in;
  logic [23:0] man_in;
  logic [9:0]  exp_in;
  logic        sgn_in;
  logic        round_bit;
  logic        sticky_bit;
  logic        skip_round;
  logic        IV_in;
  logic        DZ_in;
  logic [2:0]  rm;
  logic [31:0] float_out;
  logic [4:0]  fflags;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [23:0] m;
    logic [9:0]  e;
    logic        s, r, k, sk, iv, dz;
    logic [2:0]  mode;
    logic [31:0] res;
    logic [4:0]  fl;
  } vec_t;

  float_rounder dut (
    .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .ready_out(ready_out),
    .valid_out(valid_out), .ready_in(ready_in), .man_in(man_in),
    .exp_in(exp_in), .sgn_in(sgn_in), .round_bit(round_bit),
    .sticky_bit(sticky_bit), .skip_round(skip_round), .IV_in(IV_in),
    .DZ_in(DZ_in), .rm(rm), .float_out(float_out), .fflags(fflags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one item, then wait (bounded) for it at the output.
  task automatic run_one(input vec_t v, output logic [31:0] res,
                         output logic [4:0] fl, output bit ok, output int lat);
    man_in = v.m; exp_in = v.e; sgn_in = v.s; round_bit = v.r;
    sticky_bit = v.k; skip_round = v.sk; IV_in = v.iv; DZ_in = v.dz;
    rm = v.mode; valid_in = 1'b1; ready_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    lat = 1;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (valid_out) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
    res = float_out;
    fl = fflags;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (valid_out !== 1'b0) begin fails++; $display("FAIL reset_valid_out: got %b want 0", valid_out); end
    tests++; if (float_out !== 32'h0) begin fails++; $display("FAIL reset_float_out: got %h want 00000000", float_out); end
    tests++; if (fflags !== 5'b0) begin fails++; $display("FAIL reset_fflags: got %b want 00000", fflags); end
    reset_n = 1'b1;
    @(posedge clk); #1;
    tests++; if (ready_out !== 1'b1) begin fails++; $display("FAIL reset_ready_out: got %b want 1", ready_out); end
  endtask

  task automatic test_round_nearest();
    vec_t v[3];
    logic [31:0] res; logic [4:0] fl; bit ok; int lat;
    v[0] = '{24'h800000, 10'd127, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h3F800000, 5'b00001};
    v[1] = '{24'h800001, 10'd127, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h3F800002, 5'b00001};
    v[2] = '{24'hFFFFFF, 10'd127, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h40000000, 5'b00001};
    foreach (v[i]) begin
      run_one(v[i], res, fl, ok, lat);
      tests++;
      if (!ok || res !== v[i].res || fl !== v[i].fl) begin
        fails++; $display("FAIL rne[%0d]: got %h flags %b valid=%0d, want %h flags %b", i, res, fl, ok, v[i].res, v[i].fl);
      end
      tests++;
      if (lat != 2) begin fails++; $display("FAIL rne_latency[%0d]: got %0d want 2", i, lat); end
    end
  endtask

  task automatic test_round_modes();
    vec_t v[8];
    logic [31:0] res; logic [4:0] fl; bit ok; int lat;
    v[0] = '{24'h800000, 10'd127, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 32'h3F800001, 5'b00001};
    v[1] = '{24'h800000, 10'd127, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 32'h3F800000, 5'b00001};
    v[2] = '{24'h800000, 10'd127, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 32'hBF800001, 5'b00001};
    v[3] = '{24'h800000, 10'd127, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 32'h3F800001, 5'b00001};
    v[4] = '{24'h800001, 10'd127, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 32'h3F800001, 5'b00001};
    v[5] = '{24'h800001, 10'd127, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd7, 32'h3F800002, 5'b00001};
    v[6] = '{24'h800000, 10'd127, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 32'hBF800000, 5'b00001};
    v[7] = '{24'h812345, 10'd130, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 32'h41012345, 5'b00000};
    foreach (v[i]) begin
      run_one(v[i], res, fl, ok, lat);
      tests++;
      if (!ok || lat != 2 || res !== v[i].res || fl !== v[i].fl) begin
        fails++; $display("FAIL modes[%0d]: got %h flags %b valid=%0d lat=%0d, want %h flags %b", i, res, fl, ok, lat, v[i].res, v[i].fl);
      end
    end
  endtask

  task automatic test_overflow();
    vec_t v[6];
    logic [31:0] res; logic [4:0] fl; bit ok; int lat;
    v[0] = '{24'h800000, 10'd255, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h7F800000, 5'b00101};
    v[1] = '{24'h800000, 10'd255, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 32'h7F7FFFFF, 5'b00101};
    v[2] = '{24'h800000, 10'd255, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 32'hFF7FFFFF, 5'b00101};
    v[3] = '{24'h800000, 10'd255, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 32'hFF800000, 5'b00101};
    v[4] = '{24'hFFFFFF, 10'd254, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h7F800000, 5'b00101};
    v[5] = '{24'hFFFFFF, 10'd254, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h7F7FFFFF, 5'b00000};
    foreach (v[i]) begin
      run_one(v[i], res, fl, ok, lat);
      tests++;
      if (!ok || lat != 2 || res !== v[i].res || fl !== v[i].fl) begin
        fails++; $display("FAIL overflow[%0d]: got %h flags %b valid=%0d lat=%0d, want %h flags %b", i, res, fl, ok, lat, v[i].res, v[i].fl);
      end
    end
  endtask

  task automatic test_skip();
    vec_t v[3];
    logic [31:0] res; logic [4:0] fl; bit ok; int lat;
    v[0] = '{24'hC00000, 10'h0FF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 32'h7FC00000, 5'b10000};
    v[1] = '{24'h000000, 10'h000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 32'h80000000, 5'b01000};
    v[2] = '{24'h800000, 10'h0FF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 32'h7F800000, 5'b00000};
    foreach (v[i]) begin
      run_one(v[i], res, fl, ok, lat);
      tests++;
      if (!ok || lat != 2 || res !== v[i].res || fl !== v[i].fl) begin
        fails++; $display("FAIL skip[%0d]: got %h flags %b valid=%0d lat=%0d, want %h flags %b", i, res, fl, ok, lat, v[i].res, v[i].fl);
      end
    end
  endtask

  task automatic test_subnormal();
    vec_t v[5];
    logic [31:0] res; logic [4:0] fl; bit ok; int lat;
`ifdef FPU_ROUND_SUBNORMAL_EN
    v[0] = '{24'h800000, 10'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h00400000, 5'b00000};
    v[1] = '{24'h800000, 10'd0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h00400000, 5'b00011};
    v[2] = '{24'hFFFFFF, 10'd0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h00800000, 5'b00011};
    v[3] = '{24'h800000, 10'h3FD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h80080000, 5'b00000};
    v[4] = '{24'h800000, 10'h39C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 32'h00000001, 5'b00011};
`else
    v[0] = '{24'h800000, 10'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h00000000, 5'b00011};
    v[1] = '{24'h800000, 10'd0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h00000000, 5'b00011};
    v[2] = '{24'hFFFFFF, 10'd0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h00000000, 5'b00011};
    v[3] = '{24'h800000, 10'h3FD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h80000000, 5'b00011};
    v[4] = '{24'h800000, 10'h39C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 32'h00000000, 5'b00011};
`endif
    foreach (v[i]) begin
      run_one(v[i], res, fl, ok, lat);
      tests++;
      if (!ok || lat != 2 || res !== v[i].res || fl !== v[i].fl) begin
        fails++; $display("FAIL subnormal[%0d]: got %h flags %b valid=%0d lat=%0d, want %h flags %b", i, res, fl, ok, lat, v[i].res, v[i].fl);
      end
    end
  endtask

  task automatic test_stall();
    vec_t a;
    logic [31:0] res; logic [4:0] fl; bit ok; int lat;
    a = '{24'h800000, 10'd127, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h3F800000, 5'b00000};
    run_one(a, res, fl, ok, lat);
    tests++;
    if (!ok || res !== 32'h3F800000) begin fails++; $display("FAIL stall_first: got %h valid=%0d want 3F800000", res, ok); end
    ready_in = 1'b0;
    man_in = 24'h800001; exp_in = 10'd128; round_bit = 1'b0; sticky_bit = 1'b0;
    valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    tests++;
    if (ready_out !== 1'b0) begin fails++; $display("FAIL stall_ready_out: got %b want 0", ready_out); end
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (valid_out !== 1'b1 || float_out !== 32'h3F800000 || fflags !== 5'b0) begin
      fails++; $display("FAIL stall_hold: got valid=%b %h flags %b want 1 3F800000 00000", valid_out, float_out, fflags);
    end
    ready_in = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (valid_out !== 1'b1 || float_out !== 32'h40000001) begin
      fails++; $display("FAIL stall_second: got valid=%b %h want 1 40000001", valid_out, float_out);
    end
    @(posedge clk); #1;
    tests++;
    if (valid_out !== 1'b0) begin fails++; $display("FAIL stall_drain: got valid=%b want 0", valid_out); end
  endtask

  task automatic test_back_to_back();
    int sent, recv, limit;
    bit fin, fout;
    logic [31:0] want;
    sgn_in = 1'b0; round_bit = 1'b0; sticky_bit = 1'b0; skip_round = 1'b0;
    IV_in = 1'b0; DZ_in = 1'b0; rm = 3'd0;
    for (int ph = 0; ph < 2; ph++) begin
      sent = 0; recv = 0;
      limit = (ph == 0) ? 3 : 8;
      for (int cyc = 0; cyc < 100 && recv < limit; cyc++) begin
        ready_in = ((cyc % 2) == 0);
        if (sent < 8) begin
          man_in = 24'h800000 | 24'(sent + ph * 16);
          exp_in = 10'(110 + sent + ph * 20);
          valid_in = 1'b1;
        end else begin
          valid_in = 1'b0;
        end
        #1;
        fin = valid_in && ready_out;
        fout = valid_out && ready_in;
        if (fout) begin
          want = {1'b0, 8'(110 + recv + ph * 20), 23'(recv + ph * 16)};
          tests++;
          if (float_out !== want || fflags !== 5'b0) begin
            fails++; $display("FAIL stream%0d[%0d]: got %h flags %b want %h flags 00000", ph, recv, float_out, fflags, want);
          end
          recv++;
        end
        @(posedge clk); #1;
        if (fin) sent++;
      end
      valid_in = 1'b0;
      tests++;
      if (recv != limit) begin fails++; $display("FAIL stream%0d_count: got %0d want %0d", ph, recv, limit); end
      if (ph == 0) begin
        reset_n = 1'b0;
        #1;
        tests++;
        if (valid_out !== 1'b0 || float_out !== 32'h0 || fflags !== 5'b0 || ready_out !== 1'b1) begin
          fails++; $display("FAIL midreset_clear: got valid=%b %h flags %b ready=%b want 0 00000000 00000 1", valid_out, float_out, fflags, ready_out);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        #1;
        tests++;
        if (ready_out !== 1'b1 || valid_out !== 1'b0) begin
          fails++; $display("FAIL midreset_release: got ready=%b valid=%b want 1 0", ready_out, valid_out);
        end
        @(posedge clk); #1;
      end
    end
    ready_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      tests++;
      if (valid_out !== 1'b0) begin fails++; $display("FAIL stream_extra[%0d]: got valid=%b want 0", i, valid_out); end
    end
  endtask

  initial begin
    valid_in = 1'b0; ready_in = 1'b1; man_in = '0; exp_in = '0; sgn_in = 1'b0;
    round_bit = 1'b0; sticky_bit = 1'b0; skip_round = 1'b0; IV_in = 1'b0;
    DZ_in = 1'b0; rm = 3'd0; reset_n = 1'b0;
    test_reset();
    test_round_nearest();
    test_round_modes();
    test_overflow();
    test_skip();
    test_subnormal();
    test_stall();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
